// File: rtl/m_tlb_assoc_pkg.sv
// Shared Sv32 MMU definitions: PTE bit positions, access codes, field widths.
package m_tlb_assoc_pkg;

  // PTE permission bit positions within perm[7:0]
  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;
  localparam int unsigned PTE_G = 5;
  localparam int unsigned PTE_A = 6;
  localparam int unsigned PTE_D = 7;

  // Access type codes shared with the MMU
  localparam logic [1:0] ACCESS_LOAD  = 2'd0;
  localparam logic [1:0] ACCESS_STORE = 2'd1;
  localparam logic [1:0] ACCESS_FETCH = 2'd2;

  // Sv32 field widths
  localparam int unsigned SV32_VPN_W      = 20;
  localparam int unsigned SV32_VPN_PART_W = 10;
  localparam int unsigned SV32_PERM_W     = 8;

  // Comparator flavour: lookup/refill match vs sfence.vma selection
  typedef enum logic {
    MatchLookup = 1'b0,
    MatchFlush  = 1'b1
  } match_mode_e;

endpackage

// File: rtl/m_tlb_match.sv
// Single-entry comparator: lookup/refill hit or flush selection for one TLB entry.
module m_tlb_match
  import m_tlb_assoc_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 9
) (
  input  logic                  entry_valid_i,
  input  logic [SV32_VPN_W-1:0] entry_vpn_i,
  input  logic [ASID_WIDTH-1:0] entry_asid_i,
  input  logic                  entry_super_i,
  input  logic                  entry_global_i,
  input  logic [SV32_VPN_W-1:0] q_vpn_i,
  input  logic [ASID_WIDTH-1:0] q_asid_i,
  input  logic                  q_use_va_i,
  input  logic                  q_use_asid_i,
  input  match_mode_e           mode_i,
  output logic                  hit_o
);

  logic vpn_eq;
  logic asid_eq;

  // Superpages ignore VPN[0]; flush restrictions only apply in flush mode
  always_comb begin
    vpn_eq  = (entry_vpn_i[SV32_VPN_W-1:SV32_VPN_PART_W] == q_vpn_i[SV32_VPN_W-1:SV32_VPN_PART_W])
              && (entry_super_i
                  || (entry_vpn_i[SV32_VPN_PART_W-1:0] == q_vpn_i[SV32_VPN_PART_W-1:0]));
    asid_eq = (entry_asid_i == q_asid_i);
    hit_o   = 1'b0;
    unique case (mode_i)
      MatchLookup: hit_o = entry_valid_i && vpn_eq && (asid_eq || entry_global_i);
      MatchFlush:  hit_o = entry_valid_i && (!q_use_va_i || vpn_eq)
                           && (!q_use_asid_i || (asid_eq && !entry_global_i));
      default:     hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/m_tlb_assoc.sv
// Fully-associative Sv32 TLB with ASID tags, superpages and selective flush.
module m_tlb_assoc
  import m_tlb_assoc_pkg::*;
#(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned ASID_WIDTH = 9,
  parameter int unsigned PPN_WIDTH  = 22
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  w_lk_req,
  input  logic [19:0]           w_lk_vpn,
  input  logic [ASID_WIDTH-1:0] w_lk_asid,
  output logic                  w_lk_valid,
  output logic                  w_lk_hit,
  output logic [PPN_WIDTH-1:0]  w_lk_ppn,
  output logic [7:0]            w_lk_perm,
  input  logic                  w_rf_we,
  input  logic [19:0]           w_rf_vpn,
  input  logic [ASID_WIDTH-1:0] w_rf_asid,
  input  logic [PPN_WIDTH-1:0]  w_rf_ppn,
  input  logic [7:0]            w_rf_perm,
  input  logic                  w_rf_super,
  input  logic                  w_fl_req,
  input  logic                  w_fl_use_va,
  input  logic [19:0]           w_fl_vpn,
  input  logic                  w_fl_use_asid,
  input  logic [ASID_WIDTH-1:0] w_fl_asid,
  output logic                  w_fl_done
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [19:0]           vpn_q   [ENTRIES];
  logic [19:0]           vpn_d   [ENTRIES];
  logic [ASID_WIDTH-1:0] asid_q  [ENTRIES];
  logic [ASID_WIDTH-1:0] asid_d  [ENTRIES];
  logic [PPN_WIDTH-1:0]  ppn_q   [ENTRIES];
  logic [PPN_WIDTH-1:0]  ppn_d   [ENTRIES];
  logic [7:0]            perm_q  [ENTRIES];
  logic [7:0]            perm_d  [ENTRIES];
  logic [ENTRIES-1:0]    super_q, super_d;
  logic [IdxW-1:0]       victim_q, victim_d;

  logic                 lk_valid_q, lk_valid_d;
  logic                 lk_hit_q, lk_hit_d;
  logic [PPN_WIDTH-1:0] lk_ppn_q, lk_ppn_d;
  logic [7:0]           lk_perm_q, lk_perm_d;
  logic                 fl_done_q, fl_done_d;

  logic [ENTRIES-1:0] lk_hit, rf_hit, fl_hit;
  logic               lk_any, rf_any, free_any;
  logic [IdxW-1:0]    lk_idx, rf_idx, free_idx, rf_slot;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_match
    m_tlb_match #(.ASID_WIDTH(ASID_WIDTH)) u_lk (
      .entry_valid_i(valid_q[i]), .entry_vpn_i(vpn_q[i]), .entry_asid_i(asid_q[i]),
      .entry_super_i(super_q[i]), .entry_global_i(perm_q[i][PTE_G]),
      .q_vpn_i(w_lk_vpn), .q_asid_i(w_lk_asid), .q_use_va_i(1'b0), .q_use_asid_i(1'b0),
      .mode_i(MatchLookup), .hit_o(lk_hit[i])
    );
    m_tlb_match #(.ASID_WIDTH(ASID_WIDTH)) u_rf (
      .entry_valid_i(valid_q[i]), .entry_vpn_i(vpn_q[i]), .entry_asid_i(asid_q[i]),
      .entry_super_i(super_q[i]), .entry_global_i(perm_q[i][PTE_G]),
      .q_vpn_i(w_rf_vpn), .q_asid_i(w_rf_asid), .q_use_va_i(1'b0), .q_use_asid_i(1'b0),
      .mode_i(MatchLookup), .hit_o(rf_hit[i])
    );
    m_tlb_match #(.ASID_WIDTH(ASID_WIDTH)) u_fl (
      .entry_valid_i(valid_q[i]), .entry_vpn_i(vpn_q[i]), .entry_asid_i(asid_q[i]),
      .entry_super_i(super_q[i]), .entry_global_i(perm_q[i][PTE_G]),
      .q_vpn_i(w_fl_vpn), .q_asid_i(w_fl_asid), .q_use_va_i(w_fl_use_va),
      .q_use_asid_i(w_fl_use_asid), .mode_i(MatchFlush), .hit_o(fl_hit[i])
    );
  end

  // Lowest-index priority encoders for lookup hit, refill match and free slot
  always_comb begin
    lk_any   = 1'b0;
    rf_any   = 1'b0;
    free_any = 1'b0;
    lk_idx   = '0;
    rf_idx   = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lk_hit[i]) begin
        lk_any = 1'b1;
        lk_idx = IdxW'(i);
      end
      if (rf_hit[i]) begin
        rf_any = 1'b1;
        rf_idx = IdxW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Next-state for entries, victim pointer and the registered lookup response
  always_comb begin
    valid_d  = valid_q;
    vpn_d    = vpn_q;
    asid_d   = asid_q;
    ppn_d    = ppn_q;
    perm_d   = perm_q;
    super_d  = super_q;
    victim_d = victim_q;
    rf_slot  = '0;

    // Flush wins over a same-cycle refill; the walker retries after done
    if (w_fl_req) begin
      valid_d = valid_q & ~fl_hit;
    end else if (w_rf_we) begin
      if (rf_any) begin
        rf_slot = rf_idx;
      end else if (free_any) begin
        rf_slot = free_idx;
      end else begin
        rf_slot  = victim_q;
        victim_d = victim_q + 1'b1;
      end
      valid_d[rf_slot] = 1'b1;
      vpn_d[rf_slot]   = w_rf_vpn;
      asid_d[rf_slot]  = w_rf_asid;
      ppn_d[rf_slot]   = w_rf_ppn;
      perm_d[rf_slot]  = w_rf_perm;
      super_d[rf_slot] = w_rf_super;
    end

    // Match against pre-update contents so a same-cycle refill is not visible
    lk_valid_d = w_lk_req;
    lk_hit_d   = w_lk_req && lk_any && !w_fl_req;
    lk_ppn_d   = '0;
    lk_perm_d  = '0;
    if (lk_hit_d) begin
      lk_ppn_d  = ppn_q[lk_idx];
      lk_perm_d = perm_q[lk_idx];
      if (super_q[lk_idx]) begin
        lk_ppn_d[9:0] = w_lk_vpn[9:0];
      end
    end
    fl_done_d = w_fl_req;
  end

  // Control state with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= '0;
      victim_q   <= '0;
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_ppn_q   <= '0;
      lk_perm_q  <= '0;
      fl_done_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      victim_q   <= victim_d;
      lk_valid_q <= lk_valid_d;
      lk_hit_q   <= lk_hit_d;
      lk_ppn_q   <= lk_ppn_d;
      lk_perm_q  <= lk_perm_d;
      fl_done_q  <= fl_done_d;
    end
  end

  // Entry payload; qualified by valid so it needs no reset
  always_ff @(posedge CLK) begin
    vpn_q   <= vpn_d;
    asid_q  <= asid_d;
    ppn_q   <= ppn_d;
    perm_q  <= perm_d;
    super_q <= super_d;
  end

  assign w_lk_valid = lk_valid_q;
  assign w_lk_hit   = lk_hit_q;
  assign w_lk_ppn   = lk_ppn_q;
  assign w_lk_perm  = lk_perm_q;
  assign w_fl_done  = fl_done_q;

endmodule

// File: tb/tb_m_tlb_assoc.sv
// Scoreboard bench for m_tlb_assoc: stimulus pushes expectations, a monitor checks them.
module tb_m_tlb_assoc;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned AW      = 9;
  localparam int unsigned PW      = 22;

  logic          CLK = 1'b0;
  logic          RST;
  logic          w_lk_req;
  logic [19:0]   w_lk_vpn;
  logic [AW-1:0] w_lk_asid;
  logic          w_lk_valid, w_lk_hit;
  logic [PW-1:0] w_lk_ppn;
  logic [7:0]    w_lk_perm;
  logic          w_rf_we;
  logic [19:0]   w_rf_vpn;
  logic [AW-1:0] w_rf_asid;
  logic [PW-1:0] w_rf_ppn;
  logic [7:0]    w_rf_perm;
  logic          w_rf_super;
  logic          w_fl_req, w_fl_use_va, w_fl_use_asid;
  logic [19:0]   w_fl_vpn;
  logic [AW-1:0] w_fl_asid;
  logic          w_fl_done;

  m_tlb_assoc #(.ENTRIES(ENTRIES), .ASID_WIDTH(AW), .PPN_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST),
    .w_lk_req(w_lk_req), .w_lk_vpn(w_lk_vpn), .w_lk_asid(w_lk_asid),
    .w_lk_valid(w_lk_valid), .w_lk_hit(w_lk_hit), .w_lk_ppn(w_lk_ppn), .w_lk_perm(w_lk_perm),
    .w_rf_we(w_rf_we), .w_rf_vpn(w_rf_vpn), .w_rf_asid(w_rf_asid), .w_rf_ppn(w_rf_ppn),
    .w_rf_perm(w_rf_perm), .w_rf_super(w_rf_super),
    .w_fl_req(w_fl_req), .w_fl_use_va(w_fl_use_va), .w_fl_vpn(w_fl_vpn),
    .w_fl_use_asid(w_fl_use_asid), .w_fl_asid(w_fl_asid), .w_fl_done(w_fl_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned   cyc;
    int            id;
    logic          hit;
    logic [PW-1:0] ppn;
    logic [7:0]    perm;
  } exp_t;

  exp_t        lk_q[$];
  int unsigned fl_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every response is checked against the oldest expectation and its due cycle
  always @(negedge CLK) begin
    if (lk_q.size() > 0 && lk_q[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL lk_missing id=%0d: no response seen, required at cycle %0d",
               lk_q[0].id, lk_q[0].cyc);
      void'(lk_q.pop_front());
    end
    if (w_lk_valid) begin
      tests++;
      if (lk_q.size() == 0 || lk_q[0].cyc != cyc) begin
        fails++;
        $display("FAIL lk_unexpected: response at cycle %0d with none due", cyc);
      end else begin
        mon_e = lk_q.pop_front();
        if (w_lk_hit !== mon_e.hit || w_lk_ppn !== mon_e.ppn || w_lk_perm !== mon_e.perm) begin
          fails++;
          $display("FAIL lk id=%0d: got hit=%0b ppn=%h perm=%h, required hit=%0b ppn=%h perm=%h",
                   mon_e.id, w_lk_hit, w_lk_ppn, w_lk_perm, mon_e.hit, mon_e.ppn, mon_e.perm);
        end
      end
    end
    if (fl_q.size() > 0 && fl_q[0] < cyc) begin
      tests++;
      fails++;
      $display("FAIL fl_done_missing: no pulse, required at cycle %0d", fl_q[0]);
      void'(fl_q.pop_front());
    end
    if (w_fl_done) begin
      tests++;
      if (fl_q.size() == 0 || fl_q[0] != cyc) begin
        fails++;
        $display("FAIL fl_done_unexpected: pulse at cycle %0d with none due", cyc);
      end else begin
        void'(fl_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    w_lk_req = 0; w_lk_vpn = '0; w_lk_asid = '0;
    w_rf_we = 0; w_rf_vpn = '0; w_rf_asid = '0; w_rf_ppn = '0; w_rf_perm = '0; w_rf_super = 0;
    w_fl_req = 0; w_fl_use_va = 0; w_fl_vpn = '0; w_fl_use_asid = 0; w_fl_asid = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  task automatic set_lookup(input int id, input logic [19:0] vpn, input logic [AW-1:0] asid,
                            input logic hit, input logic [PW-1:0] ppn, input logic [7:0] perm);
    exp_t e;
    w_lk_req = 1; w_lk_vpn = vpn; w_lk_asid = asid;
    e.cyc = cyc + 1; e.id = id; e.hit = hit; e.ppn = ppn; e.perm = perm;
    lk_q.push_back(e);
  endtask

  task automatic lookup(input int id, input logic [19:0] vpn, input logic [AW-1:0] asid,
                        input logic hit, input logic [PW-1:0] ppn, input logic [7:0] perm);
    set_lookup(id, vpn, asid, hit, ppn, perm);
    step();
  endtask

  task automatic set_refill(input logic [19:0] vpn, input logic [AW-1:0] asid,
                            input logic [PW-1:0] ppn, input logic [7:0] perm, input logic sup);
    w_rf_we = 1; w_rf_vpn = vpn; w_rf_asid = asid; w_rf_ppn = ppn;
    w_rf_perm = perm; w_rf_super = sup;
  endtask

  task automatic refill(input logic [19:0] vpn, input logic [AW-1:0] asid,
                        input logic [PW-1:0] ppn, input logic [7:0] perm, input logic sup);
    set_refill(vpn, asid, ppn, perm, sup);
    step();
  endtask

  task automatic set_flush(input logic use_va, input logic [19:0] vpn,
                           input logic use_asid, input logic [AW-1:0] asid);
    w_fl_req = 1; w_fl_use_va = use_va; w_fl_vpn = vpn;
    w_fl_use_asid = use_asid; w_fl_asid = asid;
    fl_q.push_back(cyc + 1);
  endtask

  task automatic flush(input logic use_va, input logic [19:0] vpn,
                       input logic use_asid, input logic [AW-1:0] asid);
    set_flush(use_va, vpn, use_asid, asid);
    step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_lk_valid"}, 32'(w_lk_valid), 32'd0);
    chk({tag, "_lk_hit"}, 32'(w_lk_hit), 32'd0);
    chk({tag, "_lk_ppn"}, 32'(w_lk_ppn), 32'd0);
    chk({tag, "_lk_perm"}, 32'(w_lk_perm), 32'd0);
    chk({tag, "_fl_done"}, 32'(w_fl_done), 32'd0);
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    step();
    step();
    chk_idle_outputs("reset");
    RST = 0;

    // Basic refill and hit, ASID mismatch
    lookup(1, 20'h12345, 9'd1, 0, '0, '0);
    refill(20'h12345, 9'd1, 22'h000ABC, 8'hCF, 0);
    lookup(2, 20'h12345, 9'd1, 1, 22'h000ABC, 8'hCF);
    lookup(3, 20'h12345, 9'd2, 0, '0, '0);

    // Superpage: low VPN bits pass through into the PPN
    refill(20'h80000, 9'd1, 22'h200000, 8'hCF, 1);
    lookup(4, 20'h803FF, 9'd1, 1, 22'h2003FF, 8'hCF);
    lookup(5, 20'h80400, 9'd1, 0, '0, '0);

    // Global entry hits under any ASID
    refill(20'h00777, 9'd3, 22'h000777, 8'hEF, 0);
    lookup(6, 20'h00777, 9'h1FF, 1, 22'h000777, 8'hEF);

    // Duplicate refill rewrites in place (A=0 then A=1)
    refill(20'h00100, 9'd1, 22'h000100, 8'h8F, 0);
    refill(20'h00100, 9'd1, 22'h000100, 8'hCF, 0);
    lookup(7, 20'h00100, 9'd1, 1, 22'h000100, 8'hCF);

    // ASID-selective flush keeps the global entry
    flush(0, '0, 1, 9'd1);
    lookup(8, 20'h12345, 9'd1, 0, '0, '0);
    lookup(9, 20'h00777, 9'd5, 1, 22'h000777, 8'hEF);
    lookup(10, 20'h00100, 9'd1, 0, '0, '0);
    lookup(11, 20'h803FF, 9'd1, 0, '0, '0);

    // VA-selective flush hits the superpage through any address inside it
    refill(20'h80000, 9'd1, 22'h200000, 8'hCF, 1);
    lookup(12, 20'h80001, 9'd1, 1, 22'h200001, 8'hCF);
    flush(1, 20'h80123, 0, '0);
    lookup(13, 20'h80000, 9'd1, 0, '0, '0);
    lookup(14, 20'h00777, 9'd1, 1, 22'h000777, 8'hEF);

    // Full flush
    flush(0, '0, 0, '0);
    lookup(15, 20'h00777, 9'd1, 0, '0, '0);

    // Round-robin replacement: 9th refill evicts slot 0, 10th evicts slot 1
    for (int i = 0; i < 9; i++) begin
      refill(20'h10000 + 20'(i), 9'd1, 22'h000300 + 22'(i), 8'hCF, 0);
    end
    lookup(16, 20'h10000, 9'd1, 0, '0, '0);
    lookup(17, 20'h10008, 9'd1, 1, 22'h000308, 8'hCF);
    lookup(18, 20'h10001, 9'd1, 1, 22'h000301, 8'hCF);
    refill(20'h10009, 9'd1, 22'h000309, 8'hCF, 0);
    lookup(19, 20'h10001, 9'd1, 0, '0, '0);
    lookup(20, 20'h10002, 9'd1, 1, 22'h000302, 8'hCF);

    // Matching refill on a full table must not advance the victim pointer
    refill(20'h10005, 9'd1, 22'h000305, 8'h8F, 0);
    refill(20'h1000A, 9'd1, 22'h00030A, 8'hCF, 0);
    lookup(21, 20'h10002, 9'd1, 0, '0, '0);
    lookup(22, 20'h10003, 9'd1, 1, 22'h000303, 8'hCF);
    lookup(23, 20'h10005, 9'd1, 1, 22'h000305, 8'h8F);
    lookup(24, 20'h1000A, 9'd1, 1, 22'h00030A, 8'hCF);

    // Flush and refill together: refill is dropped
    set_flush(0, '0, 0, '0);
    set_refill(20'h20000, 9'd1, 22'h000400, 8'hCF, 0);
    step();
    lookup(25, 20'h20000, 9'd1, 0, '0, '0);

    // Lookup during a no-op flush misses; entry survives
    refill(20'h20000, 9'd1, 22'h000400, 8'hCF, 0);
    set_flush(1, 20'h55555, 0, '0);
    set_lookup(26, 20'h20000, 9'd1, 0, '0, '0);
    step();
    lookup(27, 20'h20000, 9'd1, 1, 22'h000400, 8'hCF);

    // Lookup with same-cycle refill sees old contents, next cycle sees new
    set_refill(20'h30000, 9'd2, 22'h000401, 8'hCF, 0);
    set_lookup(28, 20'h30000, 9'd2, 0, '0, '0);
    step();
    lookup(29, 20'h30000, 9'd2, 1, 22'h000401, 8'hCF);

    // Mid-sequence reset clears every entry
    step();
    RST = 1;
    step();
    chk_idle_outputs("midreset");
    RST = 0;
    lookup(30, 20'h20000, 9'd1, 0, '0, '0);
    lookup(31, 20'h30000, 9'd2, 0, '0, '0);

    repeat (3) step();
    chk("lk_queue_drained", 32'(lk_q.size()), 32'd0);
    chk("fl_queue_drained", 32'(fl_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
